ber_run_controller: RTL and testbench

Sequencer for one bit-error-rate measurement run over the PRBS63 pattern generator and the interleaved RS-FEC checker. It holds both blocks in reset, releases them, and enables the generator. It stops the run on a bit-count target, a frame-error target, an abort or an optional timeout. After a drain period it snapshots the checker counters for the host. It sits between the host/register interface and the generator/checker pair, and drives their `rstn` and `en` inputs.

---
 rtl/ber_run_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_ber_run_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ber_run_controller.sv
// BER run sequencer: clears, runs and drains the PRBS63 generator / RS-FEC checker pair, then snapshots counters.
// Optional RUN-state timeout is built only when BER_RUN_TIMEOUT_EN is defined.
module ber_run_controller #(
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 32,
    parameter int unsigned CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] target_bits,
    input  logic [CNT_W-1:0] target_frame_errors,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic [CNT_W-1:0] chk_total_bits,
    input  logic [CNT_W-1:0] chk_bit_errors_pre,
    input  logic [CNT_W-1:0] chk_bit_errors_post,
    input  logic [CNT_W-1:0] chk_frames,
    input  logic [CNT_W-1:0] chk_frame_errors,
    output logic             dut_rstn,
    output logic             gen_en,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [1:0]       state,
    output logic [2:0]       reason,
    output logic [CNT_W-1:0] snap_bits,
    output logic [CNT_W-1:0] snap_bit_errors_pre,
    output logic [CNT_W-1:0] snap_bit_errors_post,
    output logic [CNT_W-1:0] snap_frames,
    output logic [CNT_W-1:0] snap_frame_errors,
    output logic [CNT_W-1:0] run_cycles
);

    localparam int unsigned TMR_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [2:0] RSN_NONE    = 3'd0;
    localparam logic [2:0] RSN_BITS    = 3'd1;
    localparam logic [2:0] RSN_FRAME   = 3'd2;
    localparam logic [2:0] RSN_ABORT   = 3'd3;
`ifdef BER_RUN_TIMEOUT_EN
    localparam logic [2:0] RSN_TIMEOUT = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   tgt_bits_q, tgt_bits_d;
    logic [CNT_W-1:0]   tgt_ferr_q, tgt_ferr_d;
    logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic [CNT_W-1:0]   snap_bits_q, snap_bits_d;
    logic [CNT_W-1:0]   snap_pre_q, snap_pre_d;
    logic [CNT_W-1:0]   snap_post_q, snap_post_d;
    logic [CNT_W-1:0]   snap_frames_q, snap_frames_d;
    logic [CNT_W-1:0]   snap_ferr_q, snap_ferr_d;
    logic [2:0]         reason_q, reason_d;
    logic               result_valid_q, result_valid_d;
    logic               done_q, done_d;
    logic               dut_rstn_q, dut_rstn_d;
    logic               gen_en_q, gen_en_d;
    logic               busy_q, busy_d;
    logic               exit_c;
    logic [2:0]         exit_reason_c;

`ifdef BER_RUN_TIMEOUT_EN
    logic [CNT_W-1:0]   tgt_timeout_q, tgt_timeout_d;
`else
    logic               unused_timeout;
    assign unused_timeout = ^timeout_cycles;
`endif

    // RUN exit decision, highest priority first
    always_comb begin
        exit_c        = 1'b1;
        exit_reason_c = RSN_ABORT;
        if (stop) begin
            exit_reason_c = RSN_ABORT;
        end else if ((tgt_ferr_q != '0) && (chk_frame_errors >= tgt_ferr_q)) begin
            exit_reason_c = RSN_FRAME;
        end else if ((tgt_bits_q != '0) && (chk_total_bits >= tgt_bits_q)) begin
            exit_reason_c = RSN_BITS;
`ifdef BER_RUN_TIMEOUT_EN
        end else if ((tgt_timeout_q != '0) && (run_cycles_q >= tgt_timeout_q)) begin
            exit_reason_c = RSN_TIMEOUT;
`endif
        end else begin
            exit_c        = 1'b0;
            exit_reason_c = RSN_NONE;
        end
    end

    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        tgt_bits_d     = tgt_bits_q;
        tgt_ferr_d     = tgt_ferr_q;
        run_cycles_d   = run_cycles_q;
        snap_bits_d    = snap_bits_q;
        snap_pre_d     = snap_pre_q;
        snap_post_d    = snap_post_q;
        snap_frames_d  = snap_frames_q;
        snap_ferr_d    = snap_ferr_q;
        reason_d       = reason_q;
        result_valid_d = result_valid_q;
        done_d         = 1'b0;
`ifdef BER_RUN_TIMEOUT_EN
        tgt_timeout_d  = tgt_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    tgt_bits_d     = target_bits;
                    tgt_ferr_d     = target_frame_errors;
`ifdef BER_RUN_TIMEOUT_EN
                    tgt_timeout_d  = timeout_cycles;
`endif
                    result_valid_d = 1'b0;
                    reason_d       = RSN_NONE;
                    run_cycles_d   = '0;
                    tmr_d          = TMR_W'(CLEAR_CYCLES - 1);
                    state_d        = S_CLEAR;
                end
            end
            S_CLEAR: begin
                run_cycles_d = '0;
                if (stop) begin
                    reason_d = RSN_ABORT;
                    tmr_d    = TMR_W'(DRAIN_CYCLES - 1);
                    state_d  = S_DRAIN;
                end else if (tmr_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_RUN: begin
                // The exit cycle itself is not counted, so a timeout of N reports N
                if (exit_c) begin
                    reason_d = exit_reason_c;
                    tmr_d    = TMR_W'(DRAIN_CYCLES - 1);
                    state_d  = S_DRAIN;
                end else if (run_cycles_q != {CNT_W{1'b1}}) begin
                    run_cycles_d = run_cycles_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (tmr_q == '0) begin
                    snap_bits_d    = chk_total_bits;
                    snap_pre_d     = chk_bit_errors_pre;
                    snap_post_d    = chk_bit_errors_post;
                    snap_frames_d  = chk_frames;
                    snap_ferr_d    = chk_frame_errors;
                    done_d         = 1'b1;
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        dut_rstn_d = (state_d != S_CLEAR);
        gen_en_d   = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            tmr_q          <= '0;
            tgt_bits_q     <= '0;
            tgt_ferr_q     <= '0;
            run_cycles_q   <= '0;
            snap_bits_q    <= '0;
            snap_pre_q     <= '0;
            snap_post_q    <= '0;
            snap_frames_q  <= '0;
            snap_ferr_q    <= '0;
            reason_q       <= RSN_NONE;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            dut_rstn_q     <= 1'b1;
            gen_en_q       <= 1'b0;
            busy_q         <= 1'b0;
`ifdef BER_RUN_TIMEOUT_EN
            tgt_timeout_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            tgt_bits_q     <= tgt_bits_d;
            tgt_ferr_q     <= tgt_ferr_d;
            run_cycles_q   <= run_cycles_d;
            snap_bits_q    <= snap_bits_d;
            snap_pre_q     <= snap_pre_d;
            snap_post_q    <= snap_post_d;
            snap_frames_q  <= snap_frames_d;
            snap_ferr_q    <= snap_ferr_d;
            reason_q       <= reason_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            dut_rstn_q     <= dut_rstn_d;
            gen_en_q       <= gen_en_d;
            busy_q         <= busy_d;
`ifdef BER_RUN_TIMEOUT_EN
            tgt_timeout_q  <= tgt_timeout_d;
`endif
        end
    end

    assign state                = state_q;
    assign dut_rstn             = dut_rstn_q;
    assign gen_en               = gen_en_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign result_valid         = result_valid_q;
    assign reason               = reason_q;
    assign run_cycles           = run_cycles_q;
    assign snap_bits            = snap_bits_q;
    assign snap_bit_errors_pre  = snap_pre_q;
    assign snap_bit_errors_post = snap_post_q;
    assign snap_frames          = snap_frames_q;
    assign snap_frame_errors    = snap_ferr_q;

endmodule

// File: tb/tb_ber_run_controller.sv
// Directed bench for ber_run_controller with a simple generator/checker counter model.
module tb_ber_run_controller;

    logic        clk = 1'b0;
    logic        rstn, start, stop;
    logic [63:0] target_bits, target_frame_errors, timeout_cycles;
    logic [63:0] m_bits, m_pre, m_post, m_frames, m_ferr;
    logic        fe_set;
    logic        dut_rstn, gen_en, busy, done, result_valid;
    logic [1:0]  state;
    logic [2:0]  reason;
    logic [63:0] snap_bits, snap_pre, snap_post, snap_frames, snap_ferr, run_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ber_run_controller #(.CLEAR_CYCLES(4), .DRAIN_CYCLES(32), .CNT_W(64)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .target_bits(target_bits), .target_frame_errors(target_frame_errors),
        .timeout_cycles(timeout_cycles),
        .chk_total_bits(m_bits), .chk_bit_errors_pre(m_pre), .chk_bit_errors_post(m_post),
        .chk_frames(m_frames), .chk_frame_errors(m_ferr),
        .dut_rstn(dut_rstn), .gen_en(gen_en), .busy(busy), .done(done),
        .result_valid(result_valid), .state(state), .reason(reason),
        .snap_bits(snap_bits), .snap_bit_errors_pre(snap_pre), .snap_bit_errors_post(snap_post),
        .snap_frames(snap_frames), .snap_frame_errors(snap_ferr), .run_cycles(run_cycles)
    );

    // Checker model: counts advance while the generator is enabled, cleared by dut_rstn
    always_ff @(posedge clk) begin
        if (!dut_rstn || !rstn) begin
            m_bits <= '0; m_pre <= '0; m_post <= '0; m_frames <= '0; m_ferr <= '0;
        end else begin
            if (gen_en) begin
                m_bits   <= m_bits + 64'd10;
                m_pre    <= m_pre + 64'd2;
                m_post   <= m_post + 64'd1;
                m_frames <= m_frames + 64'd1;
            end
            if (fe_set) m_ferr <= 64'd3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
    endtask

    task automatic wait_gen(input logic lvl);
        int n = 0;
        while (gen_en !== lvl && n < 400) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; stop = 1'b0; fe_set = 1'b0;
        target_bits = '0; target_frame_errors = '0; timeout_cycles = '0;
        repeat (3) tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if ({dut_rstn, gen_en, busy, done, result_valid} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got=%b want=10000", {dut_rstn, gen_en, busy, done, result_valid}); end
        checks++; if (reason !== 3'd0 || run_cycles !== 64'd0 || snap_bits !== 64'd0) begin
            errors++; $display("FAIL reset_values reason=%0d run=%0d snap=%0d want=0", reason, run_cycles, snap_bits); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_bit_target();
        int low = 0, nd = 0, dcnt = 0;
        target_bits = 64'd1000; target_frame_errors = '0; timeout_cycles = '0;
        start = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || dut_rstn !== 1'b0) begin
            errors++; $display("FAIL start_latency busy=%b dut_rstn=%b want 1/0", busy, dut_rstn); end
        // start held into CLEAR must not restart the clear count
        while (dut_rstn === 1'b0 && low < 20) begin
            low++;
            if (low == 3) start = 1'b0;
            tick();
        end
        start = 1'b0;
        checks++; if (low != 4 || gen_en !== 1'b1) begin
            errors++; $display("FAIL clear_len got=%0d gen_en=%b want=4 gen_en=1", low, gen_en); end
        wait_gen(1'b0);
        checks++; if (gen_en !== 1'b0 || state !== 2'd3 || run_cycles !== 64'd100) begin
            errors++; $display("FAIL bit_exit gen_en=%b state=%0d run=%0d want 0/3/100", gen_en, state, run_cycles); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin dcnt++; if (dcnt == 1) nd = i + 1; end
        end
        checks++; if (nd != 32 || dcnt != 1) begin
            errors++; $display("FAIL done_timing delay=%0d pulses=%0d want 32/1", nd, dcnt); end
        checks++; if (reason !== 3'd1 || result_valid !== 1'b1) begin
            errors++; $display("FAIL bit_reason reason=%0d rv=%b want 1/1", reason, result_valid); end
        checks++; if (snap_bits !== 64'd1010 || snap_pre !== 64'd202 || snap_post !== 64'd101 || snap_frames !== 64'd101 || snap_ferr !== 64'd0) begin
            errors++; $display("FAIL bit_snap got=%0d/%0d/%0d/%0d/%0d want 1010/202/101/101/0",
                               snap_bits, snap_pre, snap_post, snap_frames, snap_ferr); end
    endtask

    task automatic test_frame_target();
        int n = 0;
        target_bits = 64'd1000; target_frame_errors = 64'd3;
        start = 1'b1; tick(); start = 1'b0;
        wait_gen(1'b1);
        // frame errors and bit count reach their targets on the same edge
        while (gen_en === 1'b1 && n < 400) begin
            if (m_bits == 64'd990) fe_set = 1'b1;
            tick(); n++;
            if (m_bits == 64'd1000) fe_set = 1'b0;
        end
        fe_set = 1'b0;
        wait_done(n);
        checks++; if (done !== 1'b1 || reason !== 3'd2) begin
            errors++; $display("FAIL frame_reason done=%b reason=%0d want 1/2", done, reason); end
        checks++; if (snap_ferr !== 64'd3 || snap_bits !== 64'd1010) begin
            errors++; $display("FAIL frame_snap ferr=%0d bits=%0d want 3/1010", snap_ferr, snap_bits); end
        tick();
    endtask

    task automatic test_stop_run();
        int n;
        target_bits = '0; target_frame_errors = '0;
        start = 1'b1; tick(); start = 1'b0;
        wait_gen(1'b1);
        for (int i = 0; i < 50; i++) begin
            start = (i == 20);
            tick();
        end
        start = 1'b0;
        checks++; if (state !== 2'd2 || gen_en !== 1'b1) begin
            errors++; $display("FAIL start_in_run state=%0d gen_en=%b want 2/1", state, gen_en); end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (gen_en !== 1'b0 || state !== 2'd3 || run_cycles !== 64'd50) begin
            errors++; $display("FAIL stop_run gen_en=%b state=%0d run=%0d want 0/3/50", gen_en, state, run_cycles); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL start_in_drain state=%0d want=3", state); end
        wait_done(n);
        checks++; if (done !== 1'b1 || n != 31 || reason !== 3'd3) begin
            errors++; $display("FAIL stop_done done=%b wait=%0d reason=%0d want 1/31/3", done, n, reason); end
        tick();
    endtask

    task automatic test_stop_clear();
        int n;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (state !== 2'd3 || reason !== 3'd3 || dut_rstn !== 1'b1 || gen_en !== 1'b0) begin
            errors++; $display("FAIL stop_clear state=%0d reason=%0d dut_rstn=%b gen_en=%b want 3/3/1/0",
                               state, reason, dut_rstn, gen_en); end
        wait_done(n);
        checks++; if (done !== 1'b1 || (snap_bits | snap_pre | snap_post | snap_frames | snap_ferr) !== 64'd0 || run_cycles !== 64'd0) begin
            errors++; $display("FAIL clear_snap done=%b bits=%0d frames=%0d run=%0d want 1/0/0/0",
                               done, snap_bits, snap_frames, run_cycles); end
        tick();
    endtask

    task automatic test_rstn_drain();
        int dcnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        wait_gen(1'b1);
        repeat (10) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (5) tick();
        rstn = 1'b0; tick();
        checks++; if (state !== 2'd0 || {dut_rstn, gen_en, busy, result_valid} !== 4'b1000) begin
            errors++; $display("FAIL rstn_drain state=%0d flags=%b want 0/1000", state, {dut_rstn, gen_en, busy, result_valid}); end
        checks++; if (reason !== 3'd0 || run_cycles !== 64'd0 || snap_frames !== 64'd0) begin
            errors++; $display("FAIL rstn_values reason=%0d run=%0d snap=%0d want 0", reason, run_cycles, snap_frames); end
        rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(); if (done) dcnt++; end
        checks++; if (dcnt != 0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL rstn_no_done pulses=%0d rv=%b want 0/0", dcnt, result_valid); end
    endtask

    task automatic test_timeout();
        int n;
        target_bits = '0; target_frame_errors = '0; timeout_cycles = 64'd200;
        start = 1'b1; tick(); start = 1'b0;
        wait_gen(1'b1);
`ifdef BER_RUN_TIMEOUT_EN
        wait_gen(1'b0);
        checks++; if (gen_en !== 1'b0 || run_cycles !== 64'd200 || reason !== 3'd4) begin
            errors++; $display("FAIL timeout gen_en=%b run=%0d reason=%0d want 0/200/4", gen_en, run_cycles, reason); end
`else
        repeat (250) tick();
        checks++; if (state !== 2'd2 || gen_en !== 1'b1) begin
            errors++; $display("FAIL no_timeout state=%0d gen_en=%b want 2/1", state, gen_en); end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (run_cycles !== 64'd250 || reason !== 3'd3) begin
            errors++; $display("FAIL no_timeout_stop run=%0d reason=%0d want 250/3", run_cycles, reason); end
`endif
        wait_done(n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done got=%b want=1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_bit_target();
        test_frame_target();
        test_stop_run();
        test_stop_clear();
        test_rstn_drain();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
